// File: rtl/pipeline_state_dump.sv
// pipeline_state_dump
//   Counts cycles, stalls and flushes for the pipelined CPU. On a trigger it
//   freezes the counters and the PC. It then reads every register and the low
//   data-memory words through the probe ports. The resulting words leave as a
//   32-bit valid/ready stream.
//
//   Word order within one snapshot:
//     cycle, stall, flush, PC, x0..x31, mem[MEM_BASE + 4*j] for j < NUM_MEM_WORDS
//     and, when enabled, a checksum word.
//
//   Optional feature (compile-time macro DUMP_CHECKSUM_EN):
//     When the macro is defined, one extra word is appended. It is the XOR of
//     all preceding words of the snapshot, and only that word carries dump_last_o.
//
// Ports
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   trigger_i             one-cycle request to take a snapshot
//   stall_i, flush_i      pipeline stall / flush indications, counted per cycle
//   pc_i                  current PC
//   reg_addr_o/reg_data_i register-file probe (data combinational from address)
//   mem_addr_o/mem_data_i data-memory probe, byte address (combinational)
//   dump_valid_o/dump_data_o/dump_last_o/dump_ready_i  output word stream
//   busy_o                a snapshot is being streamed
//   overrun_o             sticky flag: a trigger arrived while busy
module pipeline_state_dump #(
  parameter int          NUM_MEM_WORDS = 8,
  parameter logic [31:0] MEM_BASE      = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trigger_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        dump_valid_o,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  input  logic        dump_ready_i,
  output logic        busy_o,
  output logic        overrun_o
);

`ifdef DUMP_CHECKSUM_EN
  localparam int NUM_WORDS = 37 + NUM_MEM_WORDS;
`else
  localparam int NUM_WORDS = 36 + NUM_MEM_WORDS;
`endif
  localparam logic [6:0] K_LAST    = 7'(NUM_WORDS - 1);
  localparam logic [6:0] K_MEM_END = 7'(36 + NUM_MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic [31:0] r_snap_cycle;
  logic [31:0] r_snap_stall;
  logic [31:0] r_snap_flush;
  logic [31:0] r_snap_pc;

  logic [6:0]  r_k;
  logic        r_overrun;
  logic        r_dump_vld_p1;
  logic [31:0] r_dump_data_p1;
  logic        r_dump_last_p1;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] r_csum;
`endif

  logic        w_is_reg;
  logic        w_is_mem;
  logic [31:0] w_word;

  // Probe addresses follow the word index directly. Outside their ranges they
  // rest at their reset values so that the probes see a quiet address.
  assign w_is_reg   = (r_k >= 7'd4) && (r_k < 7'd36);
  assign w_is_mem   = (r_k >= 7'd36) && (r_k < K_MEM_END);
  assign reg_addr_o = w_is_reg ? 5'(r_k - 7'd4) : 5'd0;
  assign mem_addr_o = w_is_mem ? (MEM_BASE + {23'd0, 7'(r_k - 7'd36), 2'b00}) : MEM_BASE;

  always_comb begin
    w_word = '0;
    if (r_k == 7'd0)      w_word = r_snap_cycle;
    else if (r_k == 7'd1) w_word = r_snap_stall;
    else if (r_k == 7'd2) w_word = r_snap_flush;
    else if (r_k == 7'd3) w_word = r_snap_pc;
    else if (w_is_reg)    w_word = reg_data_i;
    else if (w_is_mem)    w_word = mem_data_i;
`ifdef DUMP_CHECKSUM_EN
    else                  w_word = r_csum;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (trigger_i) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_SEND;
      S_SEND:  if (dump_ready_i) w_state_next = r_dump_last_p1 ? S_IDLE : S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cycle_cnt    <= '0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
      r_snap_cycle   <= '0;
      r_snap_stall   <= '0;
      r_snap_flush   <= '0;
      r_snap_pc      <= '0;
      r_k            <= '0;
      r_overrun      <= 1'b0;
      r_dump_vld_p1  <= 1'b0;
      r_dump_data_p1 <= '0;
      r_dump_last_p1 <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_csum         <= '0;
`endif
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (stall_i) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush_i) r_flush_cnt <= r_flush_cnt + 32'd1;

      if (trigger_i && (r_state != S_IDLE)) r_overrun <= 1'b1;

      unique case (r_state)
        // Snapshot: the counters freeze with the values they hold in the trigger cycle.
        S_IDLE: begin
          if (trigger_i) begin
            r_snap_cycle <= r_cycle_cnt;
            r_snap_stall <= r_stall_cnt;
            r_snap_flush <= r_flush_cnt;
            r_snap_pc    <= pc_i;
            r_k          <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end
        // Stage p1: the selected word is registered onto the stream.
        S_LOAD: begin
          r_dump_data_p1 <= w_word;
          r_dump_vld_p1  <= 1'b1;
          r_dump_last_p1 <= (r_k == K_LAST);
`ifdef DUMP_CHECKSUM_EN
          r_csum         <= r_csum ^ w_word;
`endif
        end
        // Handshake: valid is always high here, so ready alone completes the transfer.
        S_SEND: begin
          if (dump_ready_i) begin
            r_dump_vld_p1 <= 1'b0;
            if (!r_dump_last_p1) r_k <= r_k + 7'd1;
          end
        end
        default: r_dump_vld_p1 <= 1'b0;
      endcase
    end
  end

  assign dump_valid_o = r_dump_vld_p1;
  assign dump_data_o  = r_dump_data_p1;
  assign dump_last_o  = r_dump_last_p1;
  assign busy_o       = (r_state != S_IDLE);
  assign overrun_o    = r_overrun;

endmodule
